// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and defaults: state encoding, reset PC and the bubble instruction word.
package if_fetch_unit_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HAVE = 2'd2
   } fetch_st_e;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_STEP       = 32'h0000_0004;

endpackage

// File: rtl/if_fetch_unit_adder.sv
// Plain modulo-2^W adder, used for the sequential PC increment.
module if_fetch_unit_adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry instruction buffer, bubbles when empty.
// Three cycles per instruction with 1-cycle memory; hazard_i holds the buffer, branch_i overrides everything.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        hazard_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        flush_o
);

   fetch_st_e   st_q;
   logic [31:0] pc_q;
   logic [31:0] buf_q;
   logic        kill_q;
   logic [31:0] pc_plus4;
   logic        valid;

   if_fetch_unit_adder #(.W(32)) u_pc_adder (
      .a_i   (pc_q),
      .b_i   (PC_STEP),
      .sum_o (pc_plus4)
   );

   assign valid       = (st_q == S_HAVE);
   assign imem_req_o  = (st_q == S_REQ);
   assign imem_addr_o = pc_q;
   assign instr_o     = valid ? buf_q : NOP_INSTR;
   assign pc_o        = pc_plus4;
   // A stall without a redirect must never bubble: IF/ID is holding a live instruction.
   assign flush_o     = branch_i | (~valid & ~hazard_i);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         st_q   <= S_REQ;
         pc_q   <= RESET_PC;
         buf_q  <= NOP_INSTR;
         kill_q <= 1'b0;
      end else if (branch_i) begin
         pc_q <= branch_target_i;
         case (st_q)
            S_REQ: begin
               if (imem_gnt_i) begin
                  st_q   <= S_WAIT;
                  kill_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  st_q   <= S_REQ;
                  kill_q <= 1'b0;
               end else begin
                  kill_q <= 1'b1;
               end
            end
            S_HAVE: begin
               st_q  <= S_REQ;
               buf_q <= NOP_INSTR;
            end
            default: st_q <= S_REQ;
         endcase
      end else begin
         case (st_q)
            S_REQ: begin
               if (imem_gnt_i) st_q <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  if (kill_q) begin
                     kill_q <= 1'b0;
                     st_q   <= S_REQ;
                  end else begin
                     buf_q <= imem_rdata_i;
                     st_q  <= S_HAVE;
                  end
               end
            end
            S_HAVE: begin
               if (!hazard_i) begin
                  pc_q <= pc_plus4;
                  st_q <= S_REQ;
               end
            end
            default: st_q <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: hand-sequenced memory handshakes with hand-computed expectations.
module tb_if_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        hazard_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        flush_o;

   int tests  = 0;
   int failed = 0;

   if_fetch_unit dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .hazard_i        (hazard_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_gnt_i      (imem_gnt_i),
      .imem_rvalid_i   (imem_rvalid_i),
      .imem_rdata_i    (imem_rdata_i),
      .pc_o            (pc_o),
      .instr_o         (instr_o),
      .flush_o         (flush_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n_i = 1'b0; hazard_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;

      // 1: reset
      step(); step();
      rst_n_i = 1'b1;
      #1;
      check("rst_req",   {31'd0, imem_req_o}, 32'd1);
      check("rst_addr",  imem_addr_o, 32'h0);
      check("rst_instr", instr_o, 32'h0);
      check("rst_flush", {31'd0, flush_o}, 32'd1);
      check("rst_pc",    pc_o, 32'h4);

      // 2: straight line with 1-cycle memory
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2008_0005;
      #1;
      check("wait_req",   {31'd0, imem_req_o}, 32'd0);
      check("wait_flush", {31'd0, flush_o}, 32'd1);
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("sl_instr", instr_o, 32'h2008_0005);
      check("sl_pc",    pc_o, 32'h4);
      check("sl_flush", {31'd0, flush_o}, 32'd0);
      check("sl_noreq", {31'd0, imem_req_o}, 32'd0);
      step();
      check("sl_next_req",  {31'd0, imem_req_o}, 32'd1);
      check("sl_next_addr", imem_addr_o, 32'h4);
      check("sl_empty",     instr_o, 32'h0);

      // 3: stall, empty-state and full-state
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; hazard_i = 1'b1;
      #1;
      check("stall_empty_flush", {31'd0, flush_o}, 32'd0);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2009_0003;
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_instr", instr_o, 32'h2009_0003);
         check("stall_pc",    pc_o, 32'h8);
         check("stall_req",   {31'd0, imem_req_o}, 32'd0);
         check("stall_flush", {31'd0, flush_o}, 32'd0);
         step();
      end
      hazard_i = 1'b0;
      #1;
      check("unstall_instr", instr_o, 32'h2009_0003);
      step();
      check("unstall_addr", imem_addr_o, 32'h8);
      check("unstall_req",  {31'd0, imem_req_o}, 32'd1);

      // 4: branch while waiting; the late 0xDEAD must be discarded
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; branch_i = 1'b1; branch_target_i = 32'h40;
      #1;
      check("br_wait_flush", {31'd0, flush_o}, 32'd1);
      step();
      branch_i = 1'b0;
      #1;
      check("br_wait_req", {31'd0, imem_req_o}, 32'd0);
      step();
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_DEAD;
      #1;
      check("br_kill_instr0", instr_o, 32'h0);
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("br_kill_instr1", instr_o, 32'h0);
      check("br_tgt_req",     {31'd0, imem_req_o}, 32'd1);
      check("br_tgt_addr",    imem_addr_o, 32'h40);

      // 5a: branch beats hazard in S_HAVE
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      hazard_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'h80;
      #1;
      check("brh_instr", instr_o, 32'h1111_1111);
      check("brh_pc",    pc_o, 32'h44);
      check("brh_flush", {31'd0, flush_o}, 32'd1);
      step();
      hazard_i = 1'b0; branch_i = 1'b0;
      #1;
      check("brh_drop", instr_o, 32'h0);
      check("brh_req",  {31'd0, imem_req_o}, 32'd1);
      check("brh_addr", imem_addr_o, 32'h80);

      // 5b: branch on the same cycle the request is granted
      imem_gnt_i = 1'b1; branch_i = 1'b1; branch_target_i = 32'hC0;
      step();
      imem_gnt_i = 1'b0; branch_i = 1'b0;
      #1;
      check("brg_wait", {31'd0, imem_req_o}, 32'd0);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("brg_instr", instr_o, 32'h0);
      check("brg_req",   {31'd0, imem_req_o}, 32'd1);
      check("brg_addr",  imem_addr_o, 32'hC0);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("brg_fetch_instr", instr_o, 32'h2222_2222);
      check("brg_fetch_pc",    pc_o, 32'hC4);
      step();
      check("brg_next_addr", imem_addr_o, 32'hC4);

      // 6: reset in S_WAIT with a late response after release
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; rst_n_i = 1'b0;
      step();
      rst_n_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
      #1;
      check("mrst_req",  {31'd0, imem_req_o}, 32'd1);
      check("mrst_addr", imem_addr_o, 32'h0);
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("mrst_instr",   instr_o, 32'h0);
      check("mrst_req2",    {31'd0, imem_req_o}, 32'd1);
      check("mrst_addr2",   imem_addr_o, 32'h0);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h4444_4444;
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("mrst_fetch_instr", instr_o, 32'h4444_4444);
      check("mrst_fetch_pc",    pc_o, 32'h4);

      // PC increment wraps at the top of the address space
      step();
      branch_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
      step();
      branch_i = 1'b0;
      #1;
      check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_5555;
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      #1;
      check("wrap_instr", instr_o, 32'h5555_5555);
      check("wrap_pc",    pc_o, 32'h0);
      step();
      check("wrap_next_addr", imem_addr_o, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
